// File: rtl/apb_rambus_bridge.sv
// APB3 slave bridging one FIC APB master onto NUM_PORTS RamBus register ports.
// The upper address bits pick a port, which gets an active-low chip select and a
// latch strobe until it acks. Unknown ports and ack timeouts both return PSLVERR.
module apb_rambus_bridge #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 4,
    parameter int PORT_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic                            PWRITE,
    input  logic [ADDR_WIDTH-1:0]           PADDR,
    input  logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH-1:0]           PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [PORT_ADDR_BITS-1:0]       RamBusAddress,
    output logic [DATA_WIDTH-1:0]           RamBusDataIn,
    output logic                            RamBusWrnRd,
    output logic [NUM_PORTS-1:0]            RamBusnCs,
    output logic [NUM_PORTS-1:0]            RamBusLatch,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] RamBusDataOut,
    input  logic [NUM_PORTS-1:0]            RamBusAck,
    output logic [7:0]                      ErrCount
);

    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit so a
    // disabled timeout still elaborates.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [PORT_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      wrnrd_q, wrnrd_d;
    logic [NUM_PORTS-1:0]      ncs_q, ncs_d;
    logic [NUM_PORTS-1:0]      latch_q, latch_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic                      err_event;

    // Port index widened to 32 bits so the range test against NUM_PORTS is a
    // real comparison for every parameter combination.
    logic [31:0]               idx_ext;
    logic [NUM_PORTS-1:0]      dec_onehot;
    logic [DATA_WIDTH-1:0]     port_rdata [NUM_PORTS];
    logic [DATA_WIDTH-1:0]     rdata_sel;
    logic                      ack_hit;

    assign idx_ext = 32'(PADDR[ADDR_WIDTH-1:PORT_ADDR_BITS]);

    // The latch strobe doubles as the one-hot record of the active port, so ack
    // and read data are qualified by it and acks from other ports drop out.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign dec_onehot[gi] = (idx_ext == 32'(gi));
            assign port_rdata[gi] = RamBusDataOut[gi*DATA_WIDTH +: DATA_WIDTH]
                                    & {DATA_WIDTH{latch_q[gi]}};
        end
    endgenerate

    assign ack_hit = |(RamBusAck & latch_q);

    // OR-combine the masked port data; at most one term is non-zero.
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            rdata_sel = rdata_sel | port_rdata[k];
        end
    end

    // Next-state and registered-output logic; strobes default to released.
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wrnrd_d   = wrnrd_q;
        ncs_d     = '1;
        latch_d   = '0;
        tmo_d     = tmo_q;
        err_cnt_d = err_cnt_q;
        err_event = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR[PORT_ADDR_BITS-1:0];
                    wdata_d = PWDATA;
                    wrnrd_d = PWRITE;
                    if (idx_ext < 32'(NUM_PORTS)) begin
                        ncs_d   = ~dec_onehot;
                        latch_d = dec_onehot;
                        tmo_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        err_event = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_WAIT: begin
                if (!PSEL) begin
                    // Master abandoned the transfer: drop strobes, no response.
                    state_d = ST_IDLE;
                end else if (ack_hit) begin
                    // Ack beats a coinciding timeout.
                    pready_d = 1'b1;
                    if (!wrnrd_q) begin
                        prdata_d = rdata_sel;
                    end
                    state_d = ST_DONE;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                    err_event = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    ncs_d   = ncs_q;
                    latch_d = latch_q;
                    if (TMO_EN) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_event && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers; reset releases all strobes immediately.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wrnrd_q   <= 1'b0;
            ncs_q     <= '1;
            latch_q   <= '0;
            tmo_q     <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wrnrd_q   <= wrnrd_d;
            ncs_q     <= ncs_d;
            latch_q   <= latch_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign PRDATA        = prdata_q;
    assign PREADY        = pready_q;
    assign PSLVERR       = pslverr_q;
    assign RamBusAddress = addr_q;
    assign RamBusDataIn  = wdata_q;
    assign RamBusWrnRd   = wrnrd_q;
    assign RamBusnCs     = ncs_q;
    assign RamBusLatch   = latch_q;
    assign ErrCount      = err_cnt_q;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Scoreboard bench for apb_rambus_bridge: two instances (default 4-port, and a
// 3-port one with an 8-cycle timeout), directed APB transfers, port responders.
module tb_apb_rambus_bridge;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        nrst;
    logic        psel_v [2];
    logic        penable;
    logic        pwrite;
    logic [13:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  ack_v [2];
    logic [127:0] dout_v [2];

    logic [31:0] a_prdata, b_prdata;
    logic        a_pready, b_pready, a_pslverr, b_pslverr;
    logic [11:0] a_raddr, b_raddr;
    logic [31:0] a_rdin, b_rdin;
    logic        a_rwr, b_rwr;
    logic [3:0]  a_ncs, a_latch;
    logic [2:0]  b_ncs, b_latch;
    logic [7:0]  a_errcnt, b_errcnt;

    apb_rambus_bridge u_dut_a (
        .clk(clk), .nRst(nrst), .PSEL(psel_v[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(a_prdata), .PREADY(a_pready),
        .PSLVERR(a_pslverr), .RamBusAddress(a_raddr), .RamBusDataIn(a_rdin),
        .RamBusWrnRd(a_rwr), .RamBusnCs(a_ncs), .RamBusLatch(a_latch),
        .RamBusDataOut(dout_v[0]), .RamBusAck(ack_v[0]), .ErrCount(a_errcnt)
    );

    apb_rambus_bridge #(.NUM_PORTS(3), .TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .nRst(nrst), .PSEL(psel_v[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(b_prdata), .PREADY(b_pready),
        .PSLVERR(b_pslverr), .RamBusAddress(b_raddr), .RamBusDataIn(b_rdin),
        .RamBusWrnRd(b_rwr), .RamBusnCs(b_ncs), .RamBusLatch(b_latch),
        .RamBusDataOut(dout_v[1][95:0]), .RamBusAck(ack_v[1][2:0]), .ErrCount(b_errcnt)
    );

    logic [31:0] prdata_v [2];
    logic        pready_v [2];
    logic        pslverr_v [2];
    logic [11:0] raddr_v [2];
    logic [31:0] rdin_v [2];
    logic        rwr_v [2];
    logic [3:0]  ncs_v [2];
    logic [3:0]  latch_v [2];
    logic [7:0]  errcnt_v [2];

    assign prdata_v[0] = a_prdata;          assign prdata_v[1] = b_prdata;
    assign pready_v[0] = a_pready;          assign pready_v[1] = b_pready;
    assign pslverr_v[0] = a_pslverr;        assign pslverr_v[1] = b_pslverr;
    assign raddr_v[0] = a_raddr;            assign raddr_v[1] = b_raddr;
    assign rdin_v[0] = a_rdin;              assign rdin_v[1] = b_rdin;
    assign rwr_v[0] = a_rwr;                assign rwr_v[1] = b_rwr;
    assign ncs_v[0] = a_ncs;                assign ncs_v[1] = {1'b1, b_ncs};
    assign latch_v[0] = a_latch;            assign latch_v[1] = {1'b0, b_latch};
    assign errcnt_v[0] = a_errcnt;          assign errcnt_v[1] = b_errcnt;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t_setup;
        int          errcnt;
    } rsp_t;

    typedef struct {
        logic [3:0]  ncs;
        logic [3:0]  latch;
        logic [11:0] addr;
        logic [31:0] din;
        logic        wr;
        int          t_setup;
    } stb_t;

    rsp_t rsp_q0 [$];
    rsp_t rsp_q1 [$];
    stb_t stb_q0 [$];
    stb_t stb_q1 [$];

    int n_total = 0;
    int n_pass  = 0;

    // Port responder configuration: ack on ack_port ack_dly cycles after the
    // strobe appears (negative = never); optional stuck ack on a spurious port.
    int ack_port [2] = '{0, 0};
    int ack_dly  [2] = '{-1, -1};
    int spur_port[2] = '{0, 0};
    bit spur_en  [2] = '{1'b0, 1'b0};
    int wcnt     [2];

    logic [3:0] prev_latch [2];
    logic       prev_ready [2];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    endtask

    task automatic cfg(input int d, input int port, input int dly, input bit spe, input int spp);
        ack_port[d]  = port;
        ack_dly[d]   = dly;
        spur_en[d]   = spe;
        spur_port[d] = spp;
    endtask

    task automatic push_stb(input int d, input logic [3:0] onehot, input logic [13:0] addr,
                            input logic [31:0] din, input logic wr);
        stb_t s;
        s.ncs = ~onehot; s.latch = onehot; s.addr = addr[11:0];
        s.din = din; s.wr = wr; s.t_setup = cyc;
        if (d == 0) stb_q0.push_back(s); else stb_q1.push_back(s);
    endtask

    task automatic xfer(input int d, input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                        input logic strobe, input logic [3:0] onehot, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_errcnt);
        rsp_t r;
        int n;
        @(posedge clk); #1;
        psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat;
        r.t_setup = cyc; r.errcnt = exp_errcnt;
        if (d == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
        if (strobe) push_stb(d, onehot, addr, wdata, wr);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (pready_v[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("pready_wait", d, 32'h0, 32'h1);
        @(posedge clk); #1;
        psel_v[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ncs",     d, 32'(ncs_v[d]),     32'hF);
            chk("rst_latch",   d, 32'(latch_v[d]),   32'h0);
            chk("rst_pready",  d, 32'(pready_v[d]),  32'h0);
            chk("rst_pslverr", d, 32'(pslverr_v[d]), 32'h0);
            chk("rst_prdata",  d, prdata_v[d],       32'h0);
            chk("rst_addr",    d, 32'(raddr_v[d]),   32'h0);
            chk("rst_datain",  d, rdin_v[d],         32'h0);
            chk("rst_wrnrd",   d, 32'(rwr_v[d]),     32'h0);
            chk("rst_errcnt",  d, 32'(errcnt_v[d]),  32'h0);
        end
    endtask

    // Monitor: compares strobe onsets and completed transfers against the queues.
    task automatic mon_step(input int d);
        rsp_t r;
        stb_t s;
        int   qs;
        if (latch_v[d] != 4'h0 && prev_latch[d] == 4'h0) begin
            qs = (d == 0) ? stb_q0.size() : stb_q1.size();
            if (qs == 0) begin
                chk("unexpected_strobe", d, 32'(latch_v[d]), 32'h0);
            end else begin
                if (d == 0) s = stb_q0.pop_front(); else s = stb_q1.pop_front();
                chk("strobe_latency", d, 32'(cyc - s.t_setup), 32'd1);
                chk("ncs",    d, 32'(ncs_v[d]),   32'(s.ncs));
                chk("latch",  d, 32'(latch_v[d]), 32'(s.latch));
                chk("addr",   d, 32'(raddr_v[d]), 32'(s.addr));
                chk("datain", d, rdin_v[d],       s.din);
                chk("wrnrd",  d, 32'(rwr_v[d]),   32'(s.wr));
            end
        end
        prev_latch[d] = latch_v[d];
        if (pready_v[d] === 1'b1) begin
            chk("pready_one_cycle", d, 32'(prev_ready[d]), 32'h0);
            qs = (d == 0) ? rsp_q0.size() : rsp_q1.size();
            if (qs == 0) begin
                chk("unexpected_pready", d, 32'h1, 32'h0);
            end else begin
                if (d == 0) r = rsp_q0.pop_front(); else r = rsp_q1.pop_front();
                chk("latency",      d, 32'(cyc - r.t_setup), 32'(r.lat));
                chk("pslverr",      d, 32'(pslverr_v[d]),    32'(r.err));
                chk("prdata",       d, prdata_v[d],          r.rdata);
                chk("errcount",     d, 32'(errcnt_v[d]),     32'(r.errcnt));
                chk("ncs_released", d, 32'(ncs_v[d]),        32'hF);
                chk("latch_clear",  d, 32'(latch_v[d]),      32'h0);
                $display("dut%0d xfer t=%0d lat=%0d pslverr=%0b prdata=%h errcount=%0d",
                         d, r.t_setup, cyc - r.t_setup, pslverr_v[d], prdata_v[d], errcnt_v[d]);
            end
        end
        prev_ready[d] = pready_v[d];
    endtask

    initial begin
        prev_latch[0] = 4'h0; prev_latch[1] = 4'h0;
        prev_ready[0] = 1'b0; prev_ready[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    // Port responders, driven just after each rising edge.
    initial begin
        logic [3:0] a;
        ack_v[0] = 4'h0; ack_v[1] = 4'h0;
        wcnt[0] = -1; wcnt[1] = -1;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                a = 4'h0;
                if (latch_v[d] == 4'h0) begin
                    wcnt[d] = -1;
                end else begin
                    wcnt[d] = wcnt[d] + 1;
                    if (ack_dly[d] >= 0 && wcnt[d] == ack_dly[d]) a[ack_port[d]] = 1'b1;
                    if (spur_en[d]) a[spur_port[d]] = 1'b1;
                end
                ack_v[d] = a;
            end
        end
    end

    initial begin
        nrst = 1'b0;
        psel_v[0] = 1'b0; psel_v[1] = 1'b0;
        penable = 1'b0; pwrite = 1'b0; paddr = 14'h0; pwdata = 32'h0;
        dout_v[0] = '0;
        dout_v[0][0*32 +: 32] = 32'h0BAD0000;
        dout_v[0][1*32 +: 32] = 32'hCAFE0001;
        dout_v[0][2*32 +: 32] = 32'h0BAD0002;
        dout_v[0][3*32 +: 32] = 32'h12345678;
        dout_v[1] = '0;
        dout_v[1][0*32 +: 32] = 32'hA5A50000;
        dout_v[1][1*32 +: 32] = 32'h0BAD0011;
        dout_v[1][2*32 +: 32] = 32'hFFFF2222;

        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        nrst = 1'b1;

        // Write to port 1, ack three cycles after the strobe.
        cfg(0, 1, 3, 1'b0, 0);
        xfer(0, 1'b1, 14'h1004, 32'hDEADBEEF, 1'b1, 4'b0010, 32'h0, 1'b0, 5, 0);
        // Read from port 3, ack on the first WAIT cycle.
        cfg(0, 3, 0, 1'b0, 0);
        xfer(0, 1'b0, 14'h3FFC, 32'h0, 1'b1, 4'b1000, 32'h12345678, 1'b0, 2, 0);
        // Write leaves PRDATA untouched.
        cfg(0, 2, 1, 1'b0, 0);
        xfer(0, 1'b1, 14'h2008, 32'h55AA55AA, 1'b1, 4'b0100, 32'h12345678, 1'b0, 3, 0);

        // 3-port instance: index 3 is a decode error.
        cfg(1, 0, -1, 1'b0, 0);
        xfer(1, 1'b0, 14'h3000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 1);
        // Port 0 acks in the 8th WAIT cycle while port 2 acks throughout.
        cfg(1, 0, 7, 1'b1, 2);
        xfer(1, 1'b0, 14'h0040, 32'h0, 1'b1, 4'b0001, 32'hA5A50000, 1'b0, 9, 1);
        // Only the wrong port acks: timeout, PRDATA cleared.
        cfg(1, 0, -1, 1'b1, 2);
        xfer(1, 1'b0, 14'h0044, 32'h0, 1'b1, 4'b0001, 32'h0, 1'b1, 9, 2);

        // PSEL dropped during WAIT: no response, no error count.
        cfg(1, 0, -1, 1'b0, 0);
        @(posedge clk); #1;
        psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 14'h1100; pwdata = 32'h0;
        push_stb(1, 4'b0010, 14'h1100, 32'h0, 1'b0);
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        psel_v[1] = 1'b0; penable = 1'b0;
        $display("dut1 transfer abandoned by master at t=%0d", cyc);
        repeat (2) @(posedge clk);

        // Saturating error counter.
        for (int i = 0; i < 257; i++) begin
            xfer(1, i[0], 14'h3000 | 14'((i * 4) & 32'hFFF), 32'(i), 1'b0, 4'b0000, 32'h0, 1'b1, 1,
                 (i + 3 > 255) ? 255 : i + 3);
        end

        // Reset pulsed in the middle of a WAIT.
        cfg(0, 0, -1, 1'b0, 0);
        @(posedge clk); #1;
        psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h0010; pwdata = 32'h11111111;
        push_stb(0, 4'b0001, 14'h0010, 32'h11111111, 1'b1);
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        reset_checks();
        $display("dut0 transfer aborted by reset at t=%0d", cyc);
        psel_v[0] = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;

        cfg(0, 0, 2, 1'b0, 0);
        xfer(0, 1'b1, 14'h0010, 32'h22222222, 1'b1, 4'b0001, 32'h0, 1'b0, 4, 0);
        xfer(1, 1'b0, 14'h3ABC, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_empty", 0, 32'(rsp_q0.size() + rsp_q1.size()), 32'h0);
        chk("stb_queue_empty", 0, 32'(stb_q0.size() + stb_q1.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
